// File: rtl/layer_eval_seq.sv
// Sequential evaluator for one layer of add/mul gates: captures the previous layer's values,
// then computes one gate per clock. Optional macro LAYER_EVAL_CHECK_EN rejects out-of-range gate indices at elaboration.
module layer_eval_seq #(
   parameter int ngates = 8,
   parameter int ninputs = 8,
   parameter int nbits = 8,
   parameter logic [ngates-1:0] gates_mul = '0,
   parameter int ninbits = $clog2(ninputs),
   parameter logic [ngates*ninbits-1:0] gates_in0 = '0,
   parameter logic [ngates*ninbits-1:0] gates_in1 = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [ninputs*nbits-1:0]  in_vals,
   output logic                      ready,
   output logic [ngates*nbits-1:0]   out_vals,
   output logic                      done
);
   localparam int cntbits = $clog2(ngates + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t             state;
   logic [cntbits-1:0] cnt;
   logic [nbits-1:0]   cap [ninputs];
   logic [nbits-1:0]   res [ngates];

   logic [ninbits-1:0] idx0, idx1;
   logic               gate_mul;
   logic [nbits-1:0]   opa, opb, gate_val;

   // An index matching no captured input leaves its operand at 0.
   always_comb begin
      idx0     = '0;
      idx1     = '0;
      gate_mul = 1'b0;
      for (int g = 0; g < ngates; g++) begin
         if (cnt == cntbits'(g)) begin
            idx0     = gates_in0[g*ninbits +: ninbits];
            idx1     = gates_in1[g*ninbits +: ninbits];
            gate_mul = gates_mul[g];
         end
      end
      opa = '0;
      opb = '0;
      for (int i = 0; i < ninputs; i++) begin
         if (idx0 == ninbits'(i)) opa = cap[i];
         if (idx1 == ninbits'(i)) opb = cap[i];
      end
      gate_val = gate_mul ? nbits'(opa * opb) : nbits'(opa + opb);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         ready <= 1'b1;
         done  <= 1'b0;
         for (int i = 0; i < ninputs; i++) cap[i] <= '0;
         for (int g = 0; g < ngates; g++) res[g] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (en) begin
                  for (int i = 0; i < ninputs; i++) cap[i] <= in_vals[i*nbits +: nbits];
                  cnt   <= '0;
                  ready <= 1'b0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               for (int g = 0; g < ngates; g++) begin
                  if (cnt == cntbits'(g)) res[g] <= gate_val;
               end
               if (cnt == cntbits'(ngates - 1)) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + cntbits'(1);
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < ngates; gi++) begin : g_out
         assign out_vals[gi*nbits +: nbits] = res[gi];
      end
   endgenerate

`ifdef LAYER_EVAL_CHECK_EN
   // Deliberately references a module that does not exist so a bad index stops elaboration.
   generate
      for (genvar gi = 0; gi < ngates; gi++) begin : g_chk
         if ((gates_in0[gi*ninbits +: ninbits] >= ninputs) ||
             (gates_in1[gi*ninbits +: ninbits] >= ninputs)) begin : g_bad
            layer_eval_index_out_of_range u_bad ();
         end
      end
   endgenerate
`endif

endmodule

// File: tb/tb_layer_eval_seq.sv
// Self-checking bench for layer_eval_seq: three configurations (8-gate reference layer,
// 4-gate layer with wrap and out-of-range indices, 1-gate layer), table vectors plus random runs.
module tb_layer_eval_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  en_bus = 3'b000;
   logic [63:0] in_bus = '0;
   logic [2:0]  ready_bus, done_bus;
   logic [63:0] out_a;
   logic [31:0] out_b;
   logic [7:0]  out_c;
   logic [63:0] outw [3];

   int tests = 0;
   int fails = 0;
   int ng  [3] = '{8, 4, 1};
   int nin [3] = '{8, 6, 2};
   logic [7:0] mdl [3][8];

   always #5 clk = ~clk;

   layer_eval_seq #(
      .ngates(8), .ninputs(8), .nbits(8), .gates_mul(8'ha5), .ninbits(3),
      .gates_in0({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}),
      .gates_in1({3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7})
   ) dut_a (
      .clk(clk), .rst(rst), .en(en_bus[0]), .in_vals(in_bus),
      .ready(ready_bus[0]), .out_vals(out_a), .done(done_bus[0])
   );

   layer_eval_seq #(
      .ngates(4), .ninputs(6), .nbits(8), .gates_mul(4'b1010), .ninbits(3),
      .gates_in0({3'd5, 3'd7, 3'd2, 3'd0}),
      .gates_in1({3'd7, 3'd4, 3'd3, 3'd1})
   ) dut_b (
      .clk(clk), .rst(rst), .en(en_bus[1]), .in_vals(in_bus[47:0]),
      .ready(ready_bus[1]), .out_vals(out_b), .done(done_bus[1])
   );

   layer_eval_seq #(
      .ngates(1), .ninputs(2), .nbits(8), .gates_mul(1'b0), .ninbits(1),
      .gates_in0(1'b0), .gates_in1(1'b1)
   ) dut_c (
      .clk(clk), .rst(rst), .en(en_bus[2]), .in_vals(in_bus[15:0]),
      .ready(ready_bus[2]), .out_vals(out_c), .done(done_bus[2])
   );

   assign outw[0] = out_a;
   assign outw[1] = {32'b0, out_b};
   assign outw[2] = {56'b0, out_c};

   // Gate tables, written from the layer descriptions rather than the packed parameters.
   function automatic int cfg_in0(int d, int g);
      case (d)
         0: return g;
         1: case (g) 0: return 0; 1: return 2; 2: return 7; default: return 5; endcase
         default: return 0;
      endcase
   endfunction

   function automatic int cfg_in1(int d, int g);
      case (d)
         0: return 7 - g;
         1: case (g) 0: return 1; 1: return 3; 2: return 4; default: return 7; endcase
         default: return 1;
      endcase
   endfunction

   function automatic int cfg_mul(int d, int g);
      case (d)
         0: return (165 >> g) & 1;
         1: return (10 >> g) & 1;
         default: return 0;
      endcase
   endfunction

   function automatic logic [7:0] ref_gate(int d, int g, logic [63:0] v);
      int i0, i1, a, b;
      i0 = cfg_in0(d, g);
      i1 = cfg_in1(d, g);
      a = (i0 < nin[d]) ? int'(v[i0*8 +: 8]) : 0;
      b = (i1 < nin[d]) ? int'(v[i1*8 +: 8]) : 0;
      if (cfg_mul(d, g) != 0) return 8'((a * b) % 256);
      return 8'((a + b) % 256);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input int d, input string name);
      logic [63:0] e;
      e = '0;
      for (int g = 0; g < ng[d]; g++) e[g*8 +: 8] = mdl[d][g];
      check(name, outw[d], e);
   endtask

   task automatic run(input int d, input logic [63:0] vals, input bit reassert, input bit clear_rst);
      logic [7:0] newv [8];
      int dcnt, dk;
      for (int g = 0; g < ng[d]; g++) newv[g] = ref_gate(d, g, vals);
      @(negedge clk);
      if (clear_rst) rst = 1'b0;
      in_bus = vals;
      en_bus[d] = 1'b1;
      check("ready_idle", 64'(ready_bus[d]), 64'd1);
      @(negedge clk);
      check("ready_run", 64'(ready_bus[d]), 64'd0);
      en_bus[d] = reassert;
      dcnt = 0;
      dk = -1;
      for (int k = 1; k <= ng[d] + 4; k++) begin
         @(negedge clk);
         if (k <= ng[d]) mdl[d][k-1] = newv[k-1];
         if (k >= ng[d]) en_bus[d] = 1'b0;
         else if (reassert) in_bus = {$urandom, $urandom};
         if (done_bus[d]) begin
            dcnt++;
            dk = k;
         end
         check_out(d, "out_progress");
      end
      check("done_count", 64'(dcnt), 64'd1);
      check("done_cycle", 64'(dk), 64'(ng[d]));
      check("ready_after", 64'(ready_bus[d]), 64'd1);
      $display("[TB] run dut=%0d vals=%h reassert=%0d out=%h done_k=%0d", d, vals, reassert, outw[d], dk);
   endtask

   typedef struct {
      int          d;
      logic [63:0] vals;
      logic [63:0] exp;
   } vec_t;

   localparam logic [63:0] V28 = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
   localparam logic [63:0] E28 = {8'd8, 8'd9, 8'd18, 8'd9, 8'd9, 8'd18, 8'd9, 8'd8};

   initial begin
      vec_t tbl [5];
      int dcnt;
      tbl[0] = '{0, V28, E28};
      tbl[1] = '{0, 64'h0202020202020202, 64'h0404040404040404};
      tbl[2] = '{0, {8'd128, 8'd112, 8'd96, 8'd80, 8'd64, 8'd48, 8'd32, 8'd16},
                    {8'd0, 8'd144, 8'd0, 8'd144, 8'd144, 8'd0, 8'd144, 8'd0}};
      tbl[3] = '{1, {16'h0, 8'd5, 8'd77, 8'd16, 8'd16, 8'd100, 8'd200},
                    {32'h0, 8'd0, 8'd77, 8'd0, 8'd44}};
      tbl[4] = '{2, {48'h0, 8'd250, 8'd10}, {56'h0, 8'd4}};
      for (int d = 0; d < 3; d++)
         for (int g = 0; g < 8; g++) mdl[d][g] = '0;

      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("reset_ready", 64'(ready_bus[d]), 64'd1);
         check("reset_done", 64'(done_bus[d]), 64'd0);
         check("reset_out", outw[d], 64'd0);
      end

      for (int t = 0; t < 5; t++) begin
         run(tbl[t].d, tbl[t].vals, 1'b0, t == 0);
         check("table_out", outw[tbl[t].d], tbl[t].exp);
      end

      run(0, V28, 1'b1, 1'b0);
      check("reassert_out", out_a, E28);

      // Reset in the middle of a run, after gates 0..2 have been written.
      @(negedge clk);
      in_bus = {$urandom, $urandom};
      en_bus[0] = 1'b1;
      @(negedge clk);
      en_bus[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_out", out_a, 64'd0);
      check("midrst_ready", 64'(ready_bus[0]), 64'd1);
      check("midrst_done", 64'(done_bus[0]), 64'd0);
      for (int d = 0; d < 3; d++)
         for (int g = 0; g < 8; g++) mdl[d][g] = '0;
      dcnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (done_bus[0]) dcnt++;
      end
      check("midrst_no_done", 64'(dcnt), 64'd0);
      $display("[TB] reset pulsed mid-run, out=%h ready=%0d", out_a, ready_bus[0]);
      run(0, V28, 1'b0, 1'b1);
      check("after_rst_out", out_a, E28);

      for (int r = 0; r < 20; r++) begin
         run(int'($urandom_range(0, 2)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog expired");
   end
endmodule
